// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: delays raster by PREAMBLE_LEN+GUARD_LEN+1 cycles and inserts
// preamble/guard-band control periods ahead of each video run; no backpressure.
module hdmi_period_scheduler #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] io_in_r,
    input  logic [7:0] io_in_g,
    input  logic [7:0] io_in_b,
    input  logic       io_in_hsync,
    input  logic       io_in_vsync,
    input  logic       io_in_de,
    input  logic       io_hdmi_en,
    output logic [7:0] io_out_r,
    output logic [7:0] io_out_g,
    output logic [7:0] io_out_b,
    output logic [1:0] io_mode,
    output logic [1:0] io_ctrl0,
    output logic [1:0] io_ctrl1,
    output logic [1:0] io_ctrl2,
    output logic       io_err
);
    localparam int L      = PREAMBLE_LEN + GUARD_LEN + 1;
    localparam int THRESH = PREAMBLE_LEN + GUARD_LEN;
    localparam int CW     = $clog2(THRESH + 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hsync;
        logic       vsync;
    } pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        GUARD = 2'd2
    } state_t;

    pix_t          pix_in;
    pix_t          pix_q [L];
    pix_t          dly;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic          de_prev_q;
    logic          err_q, err_d;
    logic          rise, gap_ok;
    logic [7:0]    out_r_q, out_g_q, out_b_q;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    ctrl0_q, ctrl1_q, ctrl1_d;

    assign pix_in = '{r: io_in_r, g: io_in_g, b: io_in_b, de: io_in_de,
                      hsync: io_in_hsync, vsync: io_in_vsync};
    assign dly    = pix_q[L-1];

    // Stage 0 is the input capture, the remaining L-1 stages form the delay line,
    // and the output register adds the final cycle to reach latency L.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < L; i++) pix_q[i] <= '0;
        end else begin
            pix_q[0] <= pix_in;
            for (int i = 1; i < L; i++) pix_q[i] <= pix_q[i-1];
        end
    end

    always_comb begin
        rise   = io_in_de & ~de_prev_q;
        gap_ok = 32'(gap_q) >= THRESH;
        gap_d  = io_in_de ? 4'd0 : ((gap_q == 4'd15) ? 4'd15 : gap_q + 4'd1);
        err_d  = err_q | (rise & io_hdmi_en & ~gap_ok);
    end

    // The sequence is launched from the undelayed input so that it lands exactly
    // in the L-1 control cycles that precede the delayed video run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise && io_hdmi_en && gap_ok) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                if (cnt_q == CW'(GUARD_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mode_d = 2'b00;
        if (dly.de)                mode_d = 2'b11;
        else if (state_q == PRE)   mode_d = 2'b01;
        else if (state_q == GUARD) mode_d = 2'b10;
        ctrl1_d = (mode_d == 2'b01) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= 4'd0;
            de_prev_q <= 1'b0;
            err_q     <= 1'b0;
            out_r_q   <= 8'd0;
            out_g_q   <= 8'd0;
            out_b_q   <= 8'd0;
            mode_q    <= 2'b00;
            ctrl0_q   <= 2'b00;
            ctrl1_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            de_prev_q <= io_in_de;
            err_q     <= err_d;
            out_r_q   <= dly.r;
            out_g_q   <= dly.g;
            out_b_q   <= dly.b;
            mode_q    <= mode_d;
            ctrl0_q   <= {dly.vsync, dly.hsync};
            ctrl1_q   <= ctrl1_d;
        end
    end

    assign io_out_r = out_r_q;
    assign io_out_g = out_g_q;
    assign io_out_b = out_b_q;
    assign io_mode  = mode_q;
    assign io_ctrl0 = ctrl0_q;
    assign io_ctrl1 = ctrl1_q;
    assign io_ctrl2 = 2'b00;
    assign io_err   = err_q;

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8, number of preamble cycles before each video period.
REQ-002 SHALL have parameter GUARD_LEN, default 2, number of video guard-band cycles before each video period.
REQ-003 Latency constant L = PREAMBLE_LEN+GUARD_LEN+1 (11 at defaults); SHALL NOT be a separate parameter.
REQ-004 clock  input  1  single clock for all logic, the pixel clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_in_r, io_in_g, io_in_b  input  8 each  pixel data from the raster generator.
REQ-007 io_in_hsync, io_in_vsync, io_in_de  input  1 each  raster timing.
REQ-008 io_hdmi_en  input  1  1 = HDMI period sequencing, 0 = DVI pass-through.
REQ-009 io_out_r, io_out_g, io_out_b  output  8 each  pixel data delayed by L.
REQ-010 io_mode  output  2  encoder mode: 00 CONTROL, 01 PREAMBLE, 10 GUARD, 11 VIDEO.
REQ-011 io_ctrl0, io_ctrl1, io_ctrl2  output  2 each  control symbols for blue, green and red encoders.
REQ-012 io_err  output  1  sticky short-blanking error flag.

Function
REQ-013 All outputs SHALL be registered; inputs sampled at edge n SHALL appear on io_out_*, io_ctrl0 after edge n+L.
REQ-014 An internal L-1 stage delay line SHALL carry {r,g,b,de,hsync,vsync}, followed by the output register.
REQ-015 io_mode SHALL be 11 exactly when the delayed de is 1, and io_out_r/g/b SHALL carry delayed data in every mode.
REQ-016 gap_cnt (4 bits) SHALL count consecutive sampled io_in_de=0 cycles, saturating at 15, and SHALL clear when io_in_de=1.
REQ-017 Rising edge = io_in_de sampled 1 at edge n and 0 at edge n-1; qualifying if gap_cnt >= PREAMBLE_LEN+GUARD_LEN at edge n and io_hdmi_en=1 at edge n.
REQ-018 FSM states IDLE, PRE, GUARD. A qualifying edge at n SHALL drive io_mode=01 after edges n+1..n+PREAMBLE_LEN and 10 after edges n+PREAMBLE_LEN+1..n+L-1; the FSM then returns to IDLE.
REQ-019 PRE and GUARD SHALL override only the control cycles that precede the video run; video cycles are never overridden.
REQ-020 io_ctrl0 SHALL equal delayed {vsync,hsync} in all modes.
REQ-021 io_ctrl1 SHALL be 01 in PREAMBLE and 00 otherwise; io_ctrl2 SHALL always be 00.
REQ-022 Short gap: a rising edge with gap_cnt below threshold and io_hdmi_en=1 SHALL emit no PRE or GUARD, SHALL pass video at latency L, and SHALL set io_err.
REQ-023 io_err SHALL stay set until reset.
REQ-024 io_hdmi_en=0 at the edge SHALL give pure pass-through: mode only 00 or 11, no error.
REQ-025 io_hdmi_en changes SHALL NOT alter a PRE/GUARD sequence already in progress.
REQ-026 A de run of length 1 SHALL produce a full PRE/GUARD sequence and exactly one VIDEO cycle.
REQ-027 hsync/vsync toggles during PRE/GUARD SHALL propagate to io_ctrl0 unchanged.

Reset
REQ-028 On reset the delay line and all outputs SHALL be 0: io_mode=00, ctrl=00, data=0, io_err=0.
REQ-029 On reset the FSM SHALL go to IDLE and gap_cnt SHALL be 0; the first rising edge qualifies only after 10 de=0 samples.
REQ-030 Reset asserted mid-sequence SHALL abort it; outputs are 0 after the next edge.

Verification
REQ-031 Reset, 20 idle cycles, de rise at n with r=0x12 -> mode 01 at n+1..n+8, io_ctrl1=01 there; mode 10 at n+9,n+10; mode 11 and io_out_r=0x12 at n+11.
REQ-032 hsync toggled 1->0 at n+2 during the scenario of REQ-031 -> io_ctrl0[0] falls at n+13 while io_mode=11, io_ctrl1 unaffected.
REQ-033 Blanking gap of 5 cycles between de runs -> no 01/10 before the second run, second run's video at latency 11, io_err=1 and held.
REQ-034 io_hdmi_en=0, 640-pixel de run after 160-cycle gap -> mode only 00/11, output = input delayed 11, io_err=0.
REQ-035 Reset during GUARD, then de rise 3 cycles after release -> outputs 0 the cycle after reset, no PRE/GUARD, io_err=1.
REQ-036 Single-cycle de pulse after 12 idle cycles -> 8 x 01, 2 x 10, 1 x 11, then 00.
